// File: rtl/shift_word_feeder.sv
// Word buffer and sequencer feeding a parallel-load, shift-left shift register.
// Buffers words in a FIFO, pulses load once per word and reframes the register MSB as a serial stream.
module shift_word_feeder #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [N-1:0]                 in_data,
  output logic                         in_ready,
  output logic                         load,
  output logic [N-1:0]                 data_in,
  input  logic                         shift_msb,
  output logic                         serial_out,
  output logic                         serial_valid,
  output logic                         frame_start,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [0:0]    state;
  logic [BW-1:0] bitcnt;

  logic push;
  logic pop;
  logic fifo_empty;
  logic at_last_bit;

  assign fifo_empty  = (count == '0);
  assign in_ready    = (count != LVL_FULL);
  assign push        = in_valid && in_ready;
  assign pop         = load;
  assign at_last_bit = (bitcnt == LAST_BIT);

  // A new word is requested when idle, or on the last bit so the next frame abuts this one.
  always_comb begin
    load = 1'b0;
    if (state == IDLE) begin
      load = !fifo_empty;
    end else if (at_last_bit) begin
      load = !fifo_empty;
    end
  end

  assign data_in = fifo_empty ? '0 : mem[rd_ptr];

  // FIFO storage: data only, never reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointer width wraps modulo DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bitcnt <= '0;
          if (load) state <= SHIFT;
        end
        default: begin
          if (at_last_bit) begin
            bitcnt <= '0;
            state  <= load ? SHIFT : IDLE;
          end else begin
            bitcnt <= bitcnt + BIT_ONE;
          end
        end
      endcase
    end
  end

  assign serial_valid = (state == SHIFT);
  assign serial_out   = serial_valid && shift_msb;
  assign frame_start  = serial_valid && (bitcnt == '0);
  assign busy         = serial_valid || !fifo_empty;
  assign level        = count;

endmodule

// File: tb/tb_shift_word_feeder.sv
// Randomised and directed bench for shift_word_feeder, with a shift-register stand-in
// and a queue-based model of buffered words and remaining bits of the current frame.
module tb_shift_word_feeder;
  localparam int N     = 6;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data  = '0;
  logic          in_ready;
  logic          load;
  logic [N-1:0]  data_in;
  logic          shift_msb;
  logic          serial_out;
  logic          serial_valid;
  logic          frame_start;
  logic          busy;
  logic [LW-1:0] level;

  shift_word_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load(load), .data_in(data_in), .shift_msb(shift_msb),
    .serial_out(serial_out), .serial_valid(serial_valid), .frame_start(frame_start),
    .busy(busy), .level(level)
  );

  always #5 clock = ~clock;

  // Downstream parallel-load, shift-left register
  logic [N-1:0] sr;
  assign shift_msb = sr[N-1];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  sr <= '0;
    else if (load) sr <= data_in;
    else           sr <= sr << 1;
  end

  logic [N-1:0] q[$];
  logic [N-1:0] cur;
  int           rem = 0;
  int           checks = 0;
  int           errors = 0;
  bit           last_acc;
  int           max_lvl;
  bit           saw_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("in_ready", in_ready, sz != DEPTH);
    chk("level", level, sz);
    chk("load", load, (sz != 0) && (rem <= 1));
    chk("serial_valid", serial_valid, rem != 0);
    chk("frame_start", frame_start, rem == N);
    chk("busy", busy, (rem != 0) || (sz != 0));
    chk("data_in", data_in, (sz != 0) ? q[0] : '0);
    if (rem != 0) chk("serial_out", serial_out, cur[rem-1]);
  endtask

  task automatic step(input bit v, input logic [N-1:0] d);
    int sz;
    bit ld;
    bit acc;
    @(negedge clock);
    in_valid = v;
    in_data  = d;
    #1;
    check_outputs();
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (v && !in_ready) saw_stall = 1'b1;
    sz  = q.size();
    ld  = (sz != 0) && (rem <= 1);
    acc = v && (sz != DEPTH);
    @(posedge clock);
    if (ld) begin
      cur = q.pop_front();
      rem = N;
    end else if (rem > 0) begin
      rem--;
    end
    if (acc) q.push_back(d);
    last_acc = acc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic check_reset_state();
    chk("rst_load", load, 1'b0);
    chk("rst_serial_valid", serial_valid, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_serial_out", serial_out, 1'b0);
    chk("rst_level", level, 0);
  endtask

  task automatic bound_check(input string tag, input int guard, input int limit);
    checks++;
    assert (guard < limit) else begin
      errors++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, guard, limit);
    end
  endtask

  initial begin
    logic [N-1:0] words[6];
    int idx;
    int guard;

    // Power-on reset
    #12;
    check_reset_state();
    @(negedge clock);
    reset_n = 1'b1;

    // Idle with no traffic
    idle(20);

    // Single word
    step(1'b1, 6'b101101);
    idle(10);

    // Two words back-to-back
    step(1'b1, 6'b111000);
    step(1'b1, 6'b000111);
    idle(16);

    // Sustained pressure with six distinct words
    words[0] = 6'h2A; words[1] = 6'h15; words[2] = 6'h3C;
    words[3] = 6'h03; words[4] = 6'h31; words[5] = 6'h0E;
    max_lvl = 0;
    saw_stall = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 200) begin
      step(1'b1, words[idx]);
      if (last_acc) idx++;
      guard++;
    end
    bound_check("push_all_words", guard, 200);
    idle(40);
    chk("full_level_seen", max_lvl, DEPTH);
    chk("stall_seen", saw_stall, 1'b1);
    chk("drained_level", level, 0);

    // Push landing exactly on the last bit of a lone frame
    step(1'b1, 6'b110010);
    guard = 0;
    while (!(rem == 1 && q.size() == 0) && guard < 50) begin
      step(1'b0, '0);
      guard++;
    end
    bound_check("reach_last_bit", guard, 50);
    step(1'b1, 6'b011011);
    idle(12);

    // Reset on bit 3 with two words still buffered
    step(1'b1, 6'b100110);
    step(1'b1, 6'b010101);
    step(1'b1, 6'b111111);
    guard = 0;
    while (rem != N - 3 && guard < 50) begin
      step(1'b0, '0);
      guard++;
    end
    bound_check("reach_bit3", guard, 50);
    chk("buffered_before_reset", level, 2);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    rem = 0;
    check_reset_state();
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 6'b100001);
    idle(10);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, N'($urandom));
    end
    idle(40);
    chk("final_level", level, 0);
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_word_feeder.md
Name: shift_word_feeder

Overview:
- Upstream controller for the parallel-load, shift-left shift_register.
- Buffers incoming N-bit words in a small FIFO and drives the shift register's `load` and `data_in`.
- Observes the shift register's MSB and presents it as a framed serial bitstream, MSB first, N bits per word.
- Back-to-back words stream with no idle gap between frames.

Parameters:
- N, 8, word width; must equal the shift register's N.
- DEPTH, 4, FIFO depth in words; power of two, >=2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  N  upstream word.
- in_ready  output  1  FIFO can accept a word; equals !full.
- load  output  1  to the shift register's `load`.
- data_in  output  N  to the shift register's `data_in`; equals the FIFO head word.
- shift_msb  input  1  from the shift register, `data_out[N-1]`.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid bit this cycle.
- frame_start  output  1  high on the first (MSB) bit of each word.
- busy  output  1  a word is buffered or in flight.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async): FIFO empty, level=0, state=IDLE, bit counter=0.
  - Outputs during reset: load=0, serial_valid=0, frame_start=0, busy=0, in_ready=1, serial_out=0.
  - data_in is don't-care; drive 0 when the FIFO is empty.
- FIFO:
  - Push on a rising edge when in_valid && in_ready.
  - Pop on a rising edge when load=1.
  - Head is read combinationally onto data_in.
  - Read and write pointers wrap modulo DEPTH.
  - level updates: +1 on push only, -1 on pop only, unchanged on both.
  - in_ready = (level != DEPTH). in_ready does not look ahead at a same-cycle pop.
  - A word pushed into an empty FIFO is not visible to load until the next cycle.
- FSM, states IDLE and SHIFT; 0..N-1 bit counter `bitcnt`.
  - IDLE: load = (level != 0). When load is high, go to SHIFT with bitcnt=0 at the next edge.
  - SHIFT: serial_valid=1, serial_out=shift_msb, frame_start=(bitcnt==0).
    - bitcnt increments every edge.
    - At bitcnt==N-1 (last bit), load = (level != 0).
    - If load: bitcnt=0, stay in SHIFT (new frame immediately follows).
    - Else: go to IDLE.
    - At bitcnt<N-1, load=0, so the shift register shifts left.
  - load is combinational from state, bitcnt and level. It is high for exactly one cycle per word.
- Latency:
  - Word accepted at edge t into an idle, empty block → load high in cycle t+1.
  - First serial bit (MSB) in cycle t+2.
  - Last bit in cycle t+N+1.
- Throughput: one bit per cycle sustained; frames are contiguous when the FIFO stays non-empty.
- busy = (state==SHIFT) || (level != 0).
- Mid-operation reset: everything returns to reset values immediately; buffered and in-flight words are discarded. The shift register resets to 0 on the same reset_n.
- No overflow: pushes are only accepted with in_ready=1. Underflow cannot occur: load requires level != 0.

Test Plan:
- N=6, DEPTH=4; after reset push 6'b101101 at edge t:
  - load=1 with data_in=101101 in cycle t+1.
  - serial_out = 1,0,1,1,0,1 in cycles t+2..t+7 with serial_valid=1, frame_start only in t+2.
  - busy=0 from t+8.
- Push 6'b111000 and 6'b000111 back-to-back:
  - 12 contiguous valid bits 111000000111; frame_start at bits 0 and 6.
  - load high in exactly two cycles; no serial_valid gap.
- Hold in_valid=1 with 6 distinct words while streaming:
  - level reaches 4 and in_ready=0; stalled words are accepted later in order.
  - All 6 words emerge MSB-first in order; level returns to 0.
- Push a word exactly at the last-bit cycle of the current frame with the FIFO otherwise empty:
  - IDLE for one cycle, then load.
  - serial_valid gap of exactly 1 cycle.
- Assert reset_n=0 at bit 3 of a frame with 2 words buffered:
  - Immediately serial_valid=0, level=0, in_ready=1, busy=0.
  - After release, a new push produces a clean frame with no stale bits.
- Idle after reset for 20 cycles with in_valid=0:
  - load, serial_valid, frame_start and busy all stay 0.
